weights_sa_feeder: RTL and testbench

Downstream neighbour of the per-channel weight loader. It captures the 288-byte weight bank (N_KER kernels × 9 taps, int8) when the loader pulses `ended`, and holds it in a two-entry ping-pong buffer. It streams the bank into the systolic array's weight columns with diagonal skew, one tap per column per cycle, under a ready/stall handshake. It exports a bank-free flag so the loader can be held off when both buffers are occupied.

---
 rtl/cvxif_pkg.sv | 21 ++
 rtl/weights_pingpong_buf.sv | 84 ++++++++
 rtl/weights_sa_feeder.sv | 123 ++++++++++++
 tb/tb_weights_sa_feeder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvxif_pkg.sv
// Shared constants and types for the weight-bank feeder that drives the systolic
// array weight columns.
package cvxif_pkg;

    localparam int N_KER = 32;
    localparam int N_TAP = 9;
    localparam int W_W   = 8;
    localparam int CNT_W = 6;
    localparam int NK_W  = 7;

    typedef enum logic {
        IDLE = 1'b0,
        FEED = 1'b1
    } feeder_state_e;

    // Active kernel count is bounded by the number of physical array columns.
    function automatic logic [NK_W-1:0] clamp_nk(input logic [NK_W-1:0] n, input int max_k);
        return (int'(n) > max_k) ? NK_W'(max_k) : n;
    endfunction

endpackage

// File: rtl/weights_pingpong_buf.sv
// Two-entry ping-pong store for captured weight banks, with capture/free
// bookkeeping and a sticky overflow flag for banks that arrive with no room.
module weights_pingpong_buf
    import cvxif_pkg::*;
#(
    parameter int N_KER = cvxif_pkg::N_KER,
    parameter int N_TAP = cvxif_pkg::N_TAP,
    parameter int W_W   = cvxif_pkg::W_W,
    parameter int NK_W  = cvxif_pkg::NK_W
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [N_KER*N_TAP-1:0][W_W-1:0]    weights,
    input  logic                               ended,
    input  logic [NK_W-1:0]                    n_kernels,
    input  logic                               free_rd,
    output logic [N_KER*N_TAP-1:0][W_W-1:0]    rd_weights,
    output logic [NK_W-1:0]                    rd_nk,
    output logic                               rd_avail,
    output logic                               nx_avail,
    output logic                               bank_free,
    output logic                               overflow
);

    logic [1:0][N_KER*N_TAP-1:0][W_W-1:0] mem;
    logic [1:0][NK_W-1:0]                 nk_mem;
    logic [1:0]                           full;
    logic [1:0]                           full_freed;
    logic [1:0]                           full_nx;
    logic                                 wr_ptr;
    logic                                 rd_ptr;
    logic                                 cap_req;
    logic                                 cap_en;

    // A release on this edge frees its entry before any capture looks for room.
    always_comb begin
        full_freed = full;
        if (free_rd) begin
            full_freed[rd_ptr] = 1'b0;
        end
        cap_req = ended && (n_kernels != '0);
        cap_en  = cap_req && !full_freed[wr_ptr];
        full_nx = full_freed;
        if (cap_en) begin
            full_nx[wr_ptr] = 1'b1;
        end
    end

    assign rd_weights = mem[rd_ptr];
    assign rd_nk      = nk_mem[rd_ptr];
    assign rd_avail   = full_nx[rd_ptr];
    assign nx_avail   = full_nx[~rd_ptr];
    assign bank_free  = ~(full[0] & full[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            nk_mem   <= '0;
            overflow <= 1'b0;
        end else begin
            full <= full_nx;
            if (cap_en) begin
                wr_ptr         <= ~wr_ptr;
                nk_mem[wr_ptr] <= clamp_nk(n_kernels, N_KER);
            end
            if (free_rd) begin
                rd_ptr <= ~rd_ptr;
            end
            // Entries fill and drain in order, so a full write slot means both are full.
            if (cap_req && full_freed[wr_ptr]) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap_en) begin
            mem[wr_ptr] <= weights;
        end
    end

endmodule

// File: rtl/weights_sa_feeder.sv
// Streams captured weight banks into the systolic-array weight columns with a
// diagonal skew: column k sees tap d on step k+d, under a ready/stall handshake.
module weights_sa_feeder #(
    parameter int N_KER = cvxif_pkg::N_KER,
    parameter int N_TAP = cvxif_pkg::N_TAP,
    parameter int W_W   = cvxif_pkg::W_W,
    parameter int CNT_W = cvxif_pkg::CNT_W
) (
    input  logic                               i_clk,
    input  logic                               i_rstn,
    input  logic [N_KER*N_TAP-1:0][W_W-1:0]    i_weights,
    input  logic                               i_weights_ended,
    input  logic [6:0]                         i_n_kernels,
    input  logic                               i_sa_ready,
    output logic                               o_bank_free,
    output logic [N_KER-1:0][W_W-1:0]          o_sa_w,
    output logic [N_KER-1:0]                   o_sa_w_valid,
    output logic [N_KER-1:0][3:0]              o_tap_idx,
    output logic                               o_busy,
    output logic                               o_pass_done,
    output logic                               o_overflow
);
    import cvxif_pkg::*;

    feeder_state_e                     state;
    logic [CNT_W-1:0]                  cnt;
    logic [N_KER*N_TAP-1:0][W_W-1:0]   rd_weights;
    logic [6:0]                        rd_nk;
    logic                              rd_avail;
    logic                              nx_avail;
    logic                              last_step;
    logic                              free_rd;
    logic [N_KER-1:0][W_W-1:0]         step_w;
    logic [N_KER-1:0]                  step_v;
    logic [N_KER-1:0][3:0]             step_t;

    weights_pingpong_buf #(
        .N_KER (N_KER),
        .N_TAP (N_TAP),
        .W_W   (W_W),
        .NK_W  (7)
    ) u_buf (
        .clk        (i_clk),
        .rst_n      (i_rstn),
        .weights    (i_weights),
        .ended      (i_weights_ended),
        .n_kernels  (i_n_kernels),
        .free_rd    (free_rd),
        .rd_weights (rd_weights),
        .rd_nk      (rd_nk),
        .rd_avail   (rd_avail),
        .nx_avail   (nx_avail),
        .bank_free  (o_bank_free),
        .overflow   (o_overflow)
    );

    assign last_step = (int'(cnt) == N_TAP + int'(rd_nk) - 2);
    assign free_rd   = (state == FEED) && i_sa_ready && last_step;
    assign o_busy    = (state == FEED);

    // Column k carries tap cnt-k while that offset lies inside the kernel.
    always_comb begin
        step_w = '0;
        step_v = '0;
        step_t = '0;
        for (int k = 0; k < N_KER; k++) begin
            int d;
            d = int'(cnt) - k;
            if ((d >= 0) && (d < N_TAP) && (k < int'(rd_nk))) begin
                step_w[k] = rd_weights[k*N_TAP + d];
                step_v[k] = 1'b1;
                step_t[k] = 4'(d);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= IDLE;
            cnt          <= '0;
            o_sa_w       <= '0;
            o_sa_w_valid <= '0;
            o_tap_idx    <= '0;
            o_pass_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_sa_w       <= '0;
                    o_sa_w_valid <= '0;
                    o_tap_idx    <= '0;
                    o_pass_done  <= 1'b0;
                    if (rd_avail) begin
                        state <= FEED;
                        cnt   <= '0;
                    end
                end
                FEED: begin
                    if (i_sa_ready) begin
                        o_sa_w       <= step_w;
                        o_sa_w_valid <= step_v;
                        o_tap_idx    <= step_t;
                        o_pass_done  <= last_step;
                        if (last_step) begin
                            // A queued bank restarts the pass with no idle cycle.
                            cnt <= '0;
                            if (!nx_avail) begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        o_pass_done <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weights_sa_feeder.sv
// Bench for weights_sa_feeder: directed banks drive a scoreboard of per-step
// column outputs, checked by an independent monitor every clock.
module tb_weights_sa_feeder;

    localparam int N_KER = 32;
    localparam int N_TAP = 9;
    localparam int NW    = N_KER * N_TAP;

    typedef logic [NW-1:0][7:0] wts_t;

    typedef struct packed {
        logic [N_KER-1:0]      v;
        logic [N_KER-1:0][7:0] w;
        logic [N_KER-1:0][3:0] t;
        logic                  done;
    } out_t;

    localparam int EXP_W = $bits(out_t);

    logic                  clk;
    logic                  rstn;
    wts_t                  weights;
    logic                  ended;
    logic [6:0]            n_kernels;
    logic                  sa_ready;
    logic                  bank_free;
    logic [N_KER-1:0][7:0] sa_w;
    logic [N_KER-1:0]      sa_w_valid;
    logic [N_KER-1:0][3:0] tap_idx;
    logic                  busy;
    logic                  pass_done;
    logic                  overflow;

    logic [EXP_W-1:0] exp_q[$];
    int               checks;
    int               errors;
    out_t             cur;
    out_t             got;
    logic             mon_step;
    logic             mon_busy;

    weights_sa_feeder dut (
        .i_clk           (clk),
        .i_rstn          (rstn),
        .i_weights       (weights),
        .i_weights_ended (ended),
        .i_n_kernels     (n_kernels),
        .i_sa_ready      (sa_ready),
        .o_bank_free     (bank_free),
        .o_sa_w          (sa_w),
        .o_sa_w_valid    (sa_w_valid),
        .o_tap_idx       (tap_idx),
        .o_busy          (busy),
        .o_pass_done     (pass_done),
        .o_overflow      (overflow)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Helpers
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic wts_t make_wts(input int sel);
        wts_t r;
        for (int k = 0; k < N_KER; k++) begin
            for (int t = 0; t < N_TAP; t++) begin
                case (sel)
                    0:       r[k*N_TAP+t] = 8'(k + t);
                    1:       r[k*N_TAP+t] = 8'((k * 37 + t * 11) ^ 8'h5A);
                    2:       r[k*N_TAP+t] = 8'(255 - k - t);
                    default: r[k*N_TAP+t] = 8'(k * 16 + t + 128);
                endcase
            end
        end
        return r;
    endfunction

    // Expected per-step column contents for one accepted bank.
    task automatic push_pass(input wts_t wts, input int nk);
        int n;
        n = (nk > N_KER) ? N_KER : nk;
        for (int s = 0; s < N_TAP + n - 1; s++) begin
            out_t e;
            e = '0;
            for (int k = 0; k < n; k++) begin
                if ((s - k >= 0) && (s - k < N_TAP)) begin
                    e.v[k] = 1'b1;
                    e.w[k] = wts[k*N_TAP + s - k];
                    e.t[k] = 4'(s - k);
                end
            end
            e.done = (s == N_TAP + n - 2);
            exp_q.push_back(EXP_W'(e));
        end
    endtask

    // Driver tasks
    task automatic send(input wts_t wts, input logic [6:0] nk);
        @(negedge clk);
        weights   = wts;
        n_kernels = nk;
        ended     = 1'b1;
        @(negedge clk);
        ended   = 1'b0;
        weights = ~wts;
    endtask

    task automatic wait_steps(input int n);
        int cnt_steps;
        int guard;
        cnt_steps = 0;
        guard     = 0;
        while ((cnt_steps < n) && (guard < 500)) begin
            @(posedge clk);
            if (busy && sa_ready) cnt_steps++;
            guard++;
        end
        chk("wait_steps_reached", 32'(cnt_steps), 32'(n));
    endtask

    task automatic wait_done(input string name);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!pass_done && (guard < 500));
        chk(name, 32'(pass_done), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (((exp_q.size() != 0) || busy) && (guard < 1000));
        chk(name, 32'((exp_q.size() == 0) && !busy), 32'd1);
    endtask

    // Scoreboard monitor
    always @(posedge clk) begin
        mon_step = rstn && busy && sa_ready;
        mon_busy = busy;
        #1;
        if (!rstn) begin
            cur = '0;
        end else begin
            if (mon_step) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_step: array stepped with no queued expectation");
                    cur = '0;
                end else begin
                    cur = out_t'(exp_q.pop_front());
                end
            end else begin
                cur.done = 1'b0;
                if (!mon_busy) cur = '0;
            end
            got = '{v: sa_w_valid, w: sa_w, t: tap_idx, done: pass_done};
            checks++;
            if (got !== cur) begin
                errors++;
                $display("FAIL column_out: got v=%h w=%h t=%h done=%b expected v=%h w=%h t=%h done=%b",
                         got.v, got.w, got.t, got.done, cur.v, cur.w, cur.t, cur.done);
            end
        end
    end

    // Stimulus
    initial begin
        checks    = 0;
        errors    = 0;
        rstn      = 1'b0;
        ended     = 1'b0;
        n_kernels = '0;
        weights   = '0;
        sa_ready  = 1'b1;
        cur       = '0;
        #1;
        chk("reset_valid", 32'(sa_w_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_bank_free", 32'(bank_free), 32'd1);
        chk("reset_overflow", 32'(overflow), 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Full-width bank, ready held high: 40 steps.
        push_pass(make_wts(0), 32);
        send(make_wts(0), 7'd32);
        wait_done("full_pass_done");
        chk("full_busy_after_done", 32'(busy), 32'd0);
        wait_idle("full_pass_idle");

        // Narrow bank: 4 kernels, 12 steps.
        push_pass(make_wts(1), 4);
        send(make_wts(1), 7'd4);
        wait_idle("narrow_pass_idle");

        // Zero kernels: capture discarded.
        send(make_wts(2), 7'd0);
        repeat (2) @(negedge clk);
        chk("zero_nk_busy", 32'(busy), 32'd0);
        chk("zero_nk_bank_free", 32'(bank_free), 32'd1);

        // Oversized count clamps to full width; stall 3 cycles at cnt=10.
        push_pass(make_wts(3), 32);
        send(make_wts(3), 7'd100);
        wait_steps(10);
        @(negedge clk);
        sa_ready = 1'b0;
        repeat (3) @(negedge clk);
        sa_ready = 1'b1;
        wait_idle("stall_pass_idle");

        // Back-to-back banks plus an overflowing third bank.
        push_pass(make_wts(0), 32);
        send(make_wts(0), 7'd32);
        repeat (5) @(negedge clk);
        chk("b2b_free_one_full", 32'(bank_free), 32'd1);
        push_pass(make_wts(1), 8);
        send(make_wts(1), 7'd8);
        chk("b2b_free_both_full", 32'(bank_free), 32'd0);
        send(make_wts(2), 7'd16);
        chk("overflow_set", 32'(overflow), 32'd1);
        chk("overflow_free_still_0", 32'(bank_free), 32'd0);
        wait_done("b2b_first_done");
        chk("b2b_no_bubble_busy", 32'(busy), 32'd1);
        chk("b2b_free_returns", 32'(bank_free), 32'd1);
        wait_done("b2b_second_done");
        chk("b2b_idle_after_second", 32'(busy), 32'd0);
        wait_idle("b2b_idle");
        chk("overflow_sticky", 32'(overflow), 32'd1);

        // Reset mid-pass at cnt=20.
        push_pass(make_wts(2), 32);
        send(make_wts(2), 7'd32);
        wait_steps(20);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        exp_q.delete();
        #1;
        chk("midreset_valid", 32'(sa_w_valid), 32'd0);
        chk("midreset_w_or", 32'(|sa_w), 32'd0);
        chk("midreset_tap_or", 32'(|tap_idx), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_pass_done", 32'(pass_done), 32'd0);
        chk("midreset_overflow", 32'(overflow), 32'd0);
        chk("midreset_bank_free", 32'(bank_free), 32'd1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        push_pass(make_wts(1), 2);
        send(make_wts(1), 7'd2);
        wait_idle("post_reset_pass_idle");

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
